// File: rtl/cnt_selftest.sv
// Table-driven self-test sequencer for a 4-bit counter: drives a stimulus line,
// waits HOLD cycles per step, then checks the returned count against the table.
module cnt_selftest #(
  parameter int STEPS = 9,
  parameter int HOLD  = 3
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic       wr_stim,
  input  logic [3:0] wr_exp,
  input  logic       start,
  input  logic [3:0] cnt_qout,
  output logic       aset_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [3:0] fail_step
);

  localparam logic [4:0] STEPS_W   = 5'(STEPS);
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [3:0]       step_r;
  logic [3:0]       hold_r;
  logic [STEPS-1:0] stim_r;
  logic [3:0]       exp_r [STEPS];

  logic             wr_ok_s;
  logic             mismatch_s;
  logic [3:0]       err_next_s;
  logic [3:0]       fail_next_s;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v == 4'hF) begin
      return 4'hF;
    end else begin
      return v + 4'd1;
    end
  endfunction

  // Table write qualification and the per-step compare result
  always_comb begin
    wr_ok_s     = 1'b0;
    mismatch_s  = 1'b0;
    err_next_s  = err_cnt;
    fail_next_s = fail_step;
    if (wr_en && !busy && ({1'b0, wr_addr} < STEPS_W)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
    if (cnt_qout != exp_r[step_r]) begin
      mismatch_s = 1'b1;
      err_next_s = sat_inc(err_cnt);
      if (fail_step == 4'hF) begin
        fail_next_s = step_r;
      end else begin
        fail_next_s = fail_step;
      end
    end else begin
      mismatch_s  = 1'b0;
      err_next_s  = err_cnt;
      fail_next_s = fail_step;
    end
  end

  // Stimulus/expectation table; frozen while a run is in progress
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stim_r <= {STEPS{1'b0}};
      for (int i = 0; i < STEPS; i++) begin
        exp_r[i] <= 4'h0;
      end
    end else if (wr_ok_s) begin
      stim_r[wr_addr] <= wr_stim;
      exp_r[wr_addr]  <= wr_exp;
    end
  end

  // Run sequencer with all status outputs registered
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r   <= S_IDLE;
      step_r    <= 4'd0;
      hold_r    <= 4'd0;
      aset_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= 4'd0;
      fail_step <= 4'hF;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r   <= S_DRIVE;
            step_r    <= 4'd0;
            hold_r    <= 4'd0;
            err_cnt   <= 4'd0;
            fail_step <= 4'hF;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            aset_out  <= stim_r[0];
          end
        end
        S_DRIVE: begin
          aset_out <= stim_r[step_r];
          hold_r   <= hold_r + 4'd1;
          if (hold_r == HOLD_LAST) begin
            state_r <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          err_cnt   <= err_next_s;
          fail_step <= fail_next_s;
          if (step_r == LAST_STEP) begin
            state_r  <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            aset_out <= 1'b0;
            pass     <= (err_next_s == 4'd0);
          end else begin
            state_r  <= S_DRIVE;
            step_r   <= step_r + 4'd1;
            hold_r   <= 4'd0;
            aset_out <= stim_r[step_r + 4'd1];
          end
        end
        default: begin
          state_r  <= S_IDLE;
          aset_out <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_selftest.sv
// Bench for cnt_selftest: a step-timeline model predicts every output each cycle,
// and directed runs pin latency, error counts and reset behaviour with literals.
module tb_cnt_selftest;

  localparam int STEPS   = 9;
  localparam int HOLD    = 3;
  localparam int PER     = HOLD + 1;
  localparam int RUN_LEN = STEPS * PER;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic       wr_stim = 1'b0;
  logic [3:0] wr_exp = 4'd0;
  logic       start = 1'b0;
  logic [3:0] cnt_qout = 4'd0;
  logic       aset_out, busy, done, pass;
  logic [3:0] err_cnt, fail_step;

  cnt_selftest #(.STEPS(STEPS), .HOLD(HOLD)) dut (
    .clk(clk), .arst_n(arst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_stim(wr_stim), .wr_exp(wr_exp), .start(start), .cnt_qout(cnt_qout),
    .aset_out(aset_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_step(fail_step)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // model: live table, per-run snapshot, value returned per step, run timeline
  int m_stim [16];
  int m_exp  [16];
  int r_stim [16];
  int r_exp  [16];
  int r_q    [16];
  bit m_active = 1'b0;
  bit m_done = 1'b0;
  int m_t = 0;
  int q_mode = 0;
  int aset_hist [64];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int steps_done();
    if (m_done) return STEPS;
    else if (m_active) return m_t / PER;
    else return 0;
  endfunction

  function automatic int mdl_err();
    int c = 0;
    for (int s = 0; s < steps_done(); s++) if (r_q[s] != r_exp[s]) c++;
    return (c > 15) ? 15 : c;
  endfunction

  function automatic int mdl_fail();
    for (int s = 0; s < steps_done(); s++) if (r_q[s] != r_exp[s]) return s;
    return 15;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_done = 1'b0;
    m_t = 0;
    for (int i = 0; i < 16; i++) begin
      m_stim[i] = 0;
      m_exp[i] = 0;
    end
  endtask

  // one clock: capture inputs seen at the edge, advance the model, drive cnt_qout
  task automatic tick();
    bit st, we, ws;
    int wa, we_v, s;
    st = start; we = wr_en; wa = int'(wr_addr); ws = wr_stim; we_v = int'(wr_exp);
    @(posedge clk);
    if (we && !m_active && wa < STEPS) begin
      m_stim[wa] = int'(ws);
      m_exp[wa] = we_v;
    end
    if (m_active) begin
      m_t++;
      if (m_t == RUN_LEN) begin
        m_active = 1'b0;
        m_done = 1'b1;
      end
    end else if (st) begin
      m_active = 1'b1;
      m_done = 1'b0;
      m_t = 0;
      for (int i = 0; i < 16; i++) begin
        r_stim[i] = m_stim[i];
        r_exp[i] = m_exp[i];
        r_q[i] = 0;
      end
    end
    #1;
    if (m_active) begin
      s = m_t / PER;
      cnt_qout = (q_mode == 0) ? 4'(r_exp[s]) : 4'h0;
      r_q[s] = int'(cnt_qout);
    end
  endtask

  // the one compare process: every output against the model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", int'(busy), int'(m_active));
      check("done", int'(done), int'(m_done));
      check("pass", int'(pass), (m_done && mdl_err() == 0) ? 1 : 0);
      check("err_cnt", int'(err_cnt), mdl_err());
      check("fail_step", int'(fail_step), mdl_fail());
      check("aset_out", int'(aset_out), m_active ? r_stim[m_t / PER] : 0);
    end
  end

  task automatic reset_pulse();
    #1;
    arst_n = 1'b0;
    model_reset();
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_aset", int'(aset_out), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_fail", int'(fail_step), 15);
    @(negedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  task automatic wr(input int a, input int s, input int e);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_stim = 1'(s);
    wr_exp = 4'(e);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run(input int mode, input int disturb_at, input int abort_at, output int lat);
    q_mode = mode;
    lat = 0;
    start = 1'b1;
    do begin
      tick();
      lat++;
      start = 1'b0;
      wr_en = 1'b0;
      if (lat < 64) aset_hist[lat] = int'(aset_out);
      if (lat == disturb_at) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 4'd2;
        wr_stim = 1'b1;
        wr_exp = 4'hA;
      end
      if (lat == abort_at) begin
        reset_pulse();
        return;
      end
    end while (done !== 1'b1 && lat < 200);
    if (done !== 1'b1) check("done_reached", int'(done), 1);
  endtask

  initial begin
    int lat;
    reset_pulse();
    cmp_en = 1'b1;

    // stim {1,0,...}, exp[3]=3, exp[6]=6, others 0
    for (int s = 0; s < STEPS; s++) wr(s, (s == 0) ? 1 : 0, (s == 3) ? 3 : ((s == 6) ? 6 : 0));

    run(0, -1, -1, lat);
    check("lat_tied", lat, 37);
    check("pass_tied", int'(pass), 1);
    check("err_tied", int'(err_cnt), 0);
    check("fail_tied", int'(fail_step), 15);
    check("aset_d0", aset_hist[1], 1);
    check("aset_d1", aset_hist[2], 1);
    check("aset_d2", aset_hist[3], 1);
    check("aset_step1", aset_hist[5], 0);
    check("aset_done", int'(aset_out), 0);

    run(1, -1, -1, lat);
    check("lat_zero", lat, 37);
    check("err_zero", int'(err_cnt), 2);
    check("fail_zero", int'(fail_step), 3);
    check("pass_zero", int'(pass), 0);

    run(0, 10, -1, lat);
    check("lat_dist", lat, 37);
    check("pass_dist", int'(pass), 1);
    check("err_dist", int'(err_cnt), 0);

    run(1, -1, -1, lat);
    check("err_after_dist", int'(err_cnt), 2);
    check("fail_after_dist", int'(fail_step), 3);

    for (int s = 0; s < STEPS; s++) wr(s, (s == 0) ? 1 : 0, s + 1);
    for (int k = 0; k < 2; k++) begin
      run(1, -1, -1, lat);
      check("err_all", int'(err_cnt), 9);
      check("fail_all", int'(fail_step), 0);
      check("pass_all", int'(pass), 0);
    end

    run(1, -1, 10, lat);
    check("abort_done", int'(done), 0);
    wr(9, 1, 5);
    wr(15, 1, 7);
    run(1, -1, -1, lat);
    check("lat_clear", lat, 37);
    check("pass_clear", int'(pass), 1);
    check("err_clear", int'(err_cnt), 0);
    check("aset_clear", aset_hist[1], 0);

    tick();
    tick();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnt_selftest.md
CNT_SELFTEST -- requirements
Module: cnt_selftest

Interface
REQ-001 Parameter STEPS, default 9: number of stimulus/check steps per run (1..16).
REQ-002 Parameter HOLD, default 3: clock cycles each stimulus value is held before sampling (1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  table write strobe.
REQ-006 wr_addr  input  4  table entry index.
REQ-007 wr_stim  input  1  stimulus bit for entry.
REQ-008 wr_exp  input  4  expected counter value for entry.
REQ-009 start  input  1  begin a run (sampled while idle or done).
REQ-010 cnt_qout  input  4  counter value returned by the unit under test.
REQ-011 aset_out  output  1  set/stimulus line driven to the unit under test.
REQ-012 busy  output  1  run in progress.
REQ-013 done  output  1  run complete; held until next start.
REQ-014 pass  output  1  valid when done: 1 iff no mismatches.
REQ-015 err_cnt  output  4  mismatch count, saturating at 15.
REQ-016 fail_step  output  4  index of first mismatching step; 4'hF if none.

Function
REQ-017 Table SHALL hold STEPS entries of {stim[0], exp[3:0]}; a write with wr_en=1 and wr_addr<STEPS SHALL update the entry on the rising edge.
REQ-018 Writes SHALL be ignored while busy=1 or when wr_addr>=STEPS.
REQ-019 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-020 IDLE/DONE + start=1: step<=0, hold counter<=0, err_cnt<=0, fail_step<=4'hF, done<=0, aset_out<=stim[0], go DRIVE; busy=1 from the next cycle.
REQ-021 DRIVE: aset_out SHALL equal stim[step]; hold counter increments each cycle; after HOLD cycles in DRIVE go SAMPLE.
REQ-022 SAMPLE (one cycle): compare cnt_qout with exp[step]; on mismatch err_cnt increments (saturating at 15) and fail_step<=step if still 4'hF.
REQ-023 SAMPLE with step<STEPS-1: step<=step+1, hold counter<=0, aset_out<=stim[step+1], go DRIVE.
REQ-024 SAMPLE with step=STEPS-1: go DONE; done<=1, busy<=0, aset_out<=0.
REQ-025 Start-to-done latency SHALL be exactly STEPS*(HOLD+1)+1 clock cycles.
REQ-026 pass SHALL equal (err_cnt==0) while done=1, and SHALL be 0 otherwise.
REQ-027 start while busy=1 SHALL be ignored; start in DONE SHALL restart a run with the current table.
REQ-028 A run with an unwritten table SHALL use the reset table contents.

Reset
REQ-029 arst_n=0 SHALL immediately force IDLE, aset_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_step=4'hF, step=0.
REQ-030 Reset SHALL clear all table entries to stim=0, exp=0.
REQ-031 Reset asserted mid-run SHALL abort the run; no done is produced for the aborted run.

Verification
REQ-032 Defaults; table stim={1,0,0,0,0,0,0,0,0}, cnt_qout tied to exp of each step; start -> done after 37 cycles, pass=1, err_cnt=0, fail_step=4'hF.
REQ-033 Same table, cnt_qout forced 4'h0 while exp[3]=4'h3, exp[6]=4'h6, other exps 0 -> err_cnt=2, fail_step=3, pass=0.
REQ-034 Observe aset_out during run of REQ-032 -> high for exactly the first HOLD=3 DRIVE cycles, 0 in DONE.
REQ-035 start pulsed again mid-run and wr_en with wr_addr=2 mid-run -> run and table unaffected, same result as REQ-032.
REQ-036 arst_n low at cycle 10 of a run -> busy=0, done=0, aset_out=0 immediately; table reads as all zero on next run.
REQ-037 STEPS=9, all 9 entries mismatching, run twice -> err_cnt=9 each run (cleared on start), fail_step=0.
